softmax_stream: RTL and testbench
=================================

SOFTMAX_STREAM -- requirements
Module: softmax_stream

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 16: score element width, unsigned Q(W/2).(W/2).
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 16: result element width, unsigned Q(W/2).(W/2).
REQ-003 SHALL have parameter DATA_LENGTH, default 4: elements per row, >=2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: in_data holds a valid score element.
REQ-007 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-008 SHALL have port in_data, input, INPUT_DATA_WIDTH: score element, row order index 0 first.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid result.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the result this cycle.
REQ-011 SHALL have port out_data, output, OUTPUT_DATA_WIDTH: (x[i]-min(row))^2, quantized.
REQ-012 SHALL have port out_last, output, 1: high with out_valid on element DATA_LENGTH-1.

Function
REQ-013 SHALL implement a two-state FSM: LOAD (accept row) and DRAIN (emit row).
REQ-014 SHALL transfer an element on each cycle with in_valid&in_ready (LOAD) or out_valid&out_ready (DRAIN).
REQ-015 SHALL drive in_ready=1 only in LOAD and out_valid=1 only in DRAIN; never both in one cycle.
REQ-016 SHALL store each accepted element at buf[cnt], increment cnt, and update a running min register (first element loads min unconditionally).
REQ-017 SHALL go LOAD->DRAIN on acceptance of element DATA_LENGTH-1, clear cnt, and present out_valid for element 0 in the next cycle (latency 1 cycle from last input).
REQ-018 SHALL compute out_data combinationally from buf[cnt] and min: diff=buf[cnt]-min (unsigned, never negative), sq=diff*diff (2*INPUT_DATA_WIDTH bits, Q(W).(W)).
REQ-019 SHALL quantize sq to Q(OUT/2).(OUT/2) by selecting bits [INPUT_DATA_WIDTH+OUTPUT_DATA_WIDTH/2-1 : INPUT_DATA_WIDTH-OUTPUT_DATA_WIDTH/2], discarding lower bits (truncate toward zero).
REQ-020 SHALL hold out_data, out_last and cnt stable while out_valid=1 and out_ready=0.
REQ-021 SHALL go DRAIN->LOAD on transfer of element DATA_LENGTH-1 and be able to accept the next row's element 0 in the following cycle.
REQ-022 SHALL treat equal elements normally: all-equal row yields all-zero outputs.

Reset
REQ-023 SHALL on rst_n=0, immediately and regardless of state: state=LOAD, cnt=0, min=0, in_ready=1 after release, out_valid=0, out_last=0, out_data=0; buf contents need not be reset.
REQ-024 SHALL discard any partial row on reset mid-LOAD or mid-DRAIN; the first element after release is element 0 of a new row.

Configuration
REQ-025 SHALL, with SOFTMAX_STREAM_SAT_EN defined, output all-ones when any sq bit above the selected field is set.
REQ-026 SHALL, without SOFTMAX_STREAM_SAT_EN, output the selected field only (upper bits dropped, wrap).

Structure
REQ-027 SHALL place FSM state encoding (LOAD, DRAIN) and the quantization bit-position constants in shared package softmax_pkg.
REQ-028 SHALL implement the subtract-square-quantize datapath in one sub-module sq_diff_quant; buffer, counter, min tracker and FSM stay in softmax_stream.

Verification
REQ-029 SHALL check row 0x0500,0x0300,0x0700,0x0300, out_ready=1 -> out_data 0x0400,0x0000,0x1000,0x0000, out_last on 4th, first out_valid 1 cycle after last input.
REQ-030 SHALL check row 0x1300,0x0300,0x0300,0x0300 -> element 0 = 0xFFFF with SOFTMAX_STREAM_SAT_EN, 0x0000 without.
REQ-031 SHALL check out_ready low 3 cycles at element 1 -> out_data/out_last held, no element skipped or repeated, in_ready stays 0.
REQ-032 SHALL check rst_n pulsed low after 2 of 4 inputs -> outputs zero at once; next 4 inputs 0x0100 x4 -> 0x0000 x4.
REQ-033 SHALL check back-to-back rows with in_valid always 1 -> in_ready reasserts the cycle after row 0's out_last transfer; row 1 results correct.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared FSM encoding and quantization bit-position helpers for softmax_stream.
package softmax_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // The squared difference is Q(IW).(IW); the output field keeps OW/2 bits on each side of the point.
  function automatic int quant_lo(input int iw, input int ow);
    return iw - ow / 2;
  endfunction

  function automatic int quant_hi(input int iw, input int ow);
    return iw + ow / 2 - 1;
  endfunction

endpackage

// File: rtl/sq_diff_quant.sv
// Subtract-square-quantize datapath: (value - min_val)^2 reduced to the output fixed-point field.
// SOFTMAX_STREAM_SAT_EN selects saturation to all-ones instead of wrapping on overflow.
module sq_diff_quant
  import softmax_pkg::*;
#(
  parameter int IW = 16,
  parameter int OW = 16
) (
  input  logic [IW-1:0] value,
  input  logic [IW-1:0] min_val,
  output logic [OW-1:0] result
);

  localparam int LO = quant_lo(IW, OW);
  localparam int HI = quant_hi(IW, OW);

  logic [IW-1:0]   diff;
  logic [2*IW-1:0] sq;
  logic [OW-1:0]   field;
  logic            overflow;

  // min_val never exceeds value, so the unsigned difference cannot wrap.
  assign diff  = value - min_val;
  assign sq    = {{IW{1'b0}}, diff} * {{IW{1'b0}}, diff};
  assign field = sq[HI:LO];

`ifdef SOFTMAX_STREAM_SAT_EN
  if (HI < 2 * IW - 1) begin : g_ovf
    assign overflow = |sq[2*IW-1:HI+1];
  end else begin : g_no_ovf
    assign overflow = 1'b0;
  end
`else
  assign overflow = 1'b0;
`endif

  assign result = overflow ? {OW{1'b1}} : field;

endmodule

// File: rtl/softmax_stream.sv
// Row-buffered stream: loads DATA_LENGTH scores, then emits (x[i]-min(row))^2 per element.
// Optional SOFTMAX_STREAM_SAT_EN makes the quantizer saturate instead of wrap.
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int CW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_LENGTH - 1);

  state_t                        state_reg, state_next;
  logic [CW-1:0]                 cnt_reg;
  logic [INPUT_DATA_WIDTH-1:0]   min_reg;
  logic [INPUT_DATA_WIDTH-1:0]   row_mem [DATA_LENGTH];
  logic [OUTPUT_DATA_WIDTH-1:0]  quant;
  logic                          accept, emit, at_last;

  assign accept  = in_valid && in_ready;
  assign emit    = out_valid && out_ready;
  assign at_last = (cnt_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_LOAD;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD:  if (accept && at_last) state_next = ST_DRAIN;
      ST_DRAIN: if (emit && at_last)   state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  // Output data is gated so nothing from the unreset buffer leaks out while loading.
  always_comb begin
    in_ready  = (state_reg == ST_LOAD);
    out_valid = (state_reg == ST_DRAIN);
    out_last  = out_valid && at_last;
    out_data  = out_valid ? quant : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      min_reg <= '0;
    end else if (accept) begin
      cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
      if (cnt_reg == '0 || in_data < min_reg) min_reg <= in_data;
    end else if (emit) begin
      cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) row_mem[cnt_reg] <= in_data;
  end

  sq_diff_quant #(
    .IW (INPUT_DATA_WIDTH),
    .OW (OUTPUT_DATA_WIDTH)
  ) u_quant (
    .value   (row_mem[cnt_reg]),
    .min_val (min_reg),
    .result  (quant)
  );

endmodule

// File: tb/tb_softmax_stream.sv
// Scoreboard bench for softmax_stream: a row-level reference model feeds an expected queue,
// a negedge monitor pops and compares on every output transfer.
module tb_softmax_stream;

  localparam int IW = 16;
  localparam int OW = 16;
  localparam int DL = 4;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [IW-1:0] in_data;
  logic [OW-1:0] out_data;

  int total = 0;
  int bad   = 0;

  exp_t          sb[$];
  logic [IW-1:0] row[$];
  int            cyc = 0;
  int            last_in_cyc = 0;
  bit            lat_pending = 0;
  bit            rdy_pending = 0;
  bit            rand_done = 0;

  softmax_stream #(
    .INPUT_DATA_WIDTH  (IW),
    .OUTPUT_DATA_WIDTH (OW),
    .DATA_LENGTH       (DL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s value=%0h (t=%0t)", name, got, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout/none exp=event (t=%0t)", name, $time);
  endtask

  // Reference: square of distance from the row minimum in real-number terms, scaled to the output grid.
  function automatic logic [OW-1:0] ref_q(input longint unsigned d);
    longint unsigned sq, field;
    sq    = d * d;
    field = (sq >> (IW - OW / 2)) & ((64'd1 << OW) - 1);
`ifdef SOFTMAX_STREAM_SAT_EN
    if ((sq >> (IW + OW / 2)) != 0) field = (64'd1 << OW) - 1;
`endif
    return field[OW-1:0];
  endfunction

  // Monitor: checks every output transfer and builds expectations from accepted inputs.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rdy_pending) begin
          check("in_ready_after_last", {63'd0, in_ready}, 64'd1);
          rdy_pending = 0;
        end
        if (out_valid && in_ready) check("handshake_exclusive", 64'd1, 64'd0);
        if (lat_pending && out_valid) begin
          check("latency", 64'(cyc - last_in_cyc), 64'd1);
          lat_pending = 0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            fail("unexpected_output");
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", {48'd0, out_data}, {48'd0, e.d});
            check("out_last", {63'd0, out_last}, {63'd0, e.l});
          end
          if (out_last) rdy_pending = 1;
        end
        if (in_valid && in_ready) begin
          row.push_back(in_data);
          if (row.size() == DL) begin
            logic [IW-1:0] mn;
            mn = row[0];
            foreach (row[i]) if (row[i] < mn) mn = row[i];
            foreach (row[i]) sb.push_back('{d: ref_q(64'(row[i] - mn)), l: (i == DL - 1)});
            row.delete();
            last_in_cyc = cyc;
            lat_pending = 1;
          end
        end
      end
      cyc++;
    end
  end

  task automatic send(input logic [IW-1:0] v);
    int n;
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        fail("in_ready_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    row.delete();
    sb.delete();
    lat_pending = 0;
    rdy_pending = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_out_data"}, {48'd0, out_data}, 64'd0);
    check({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [OW-1:0] held_d;
    logic          held_l;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1 check_idle_outputs("in_reset");
    repeat (2) @(posedge clk);
    release_reset();
    check_idle_outputs("post_reset");

    // Basic row with two minima.
    send(16'h0500); send(16'h0300); send(16'h0700); send(16'h0300);
    in_valid = 1'b0;
    wait_idle();

    // Overflowing square: saturates or wraps depending on build.
    send(16'h1300); send(16'h0300); send(16'h0300); send(16'h0300);
    in_valid = 1'b0;
    wait_idle();

    // Backpressure for three cycles on element 1.
    out_ready = 1'b0;
    send(16'h0200); send(16'h0900); send(16'h0100); send(16'h0400);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    held_d = out_data;
    held_l = out_last;
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check("stall_elem1_data", {48'd0, held_d}, {48'd0, ref_q(64'h0800)});
    repeat (2) begin
      @(negedge clk);
      check("stall_hold_data", {48'd0, out_data}, {48'd0, held_d});
      check("stall_hold_last", {63'd0, out_last}, {63'd0, held_l});
      check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Reset after two of four inputs; the next four form a fresh row.
    send(16'h0900); send(16'h0200);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset_mid_load");
    clear_model();
    release_reset();
    repeat (DL) send(16'h0100);
    in_valid = 1'b0;
    wait_idle();

    // Reset while draining.
    out_ready = 1'b0;
    send(16'h0A00); send(16'h0100); send(16'h0300); send(16'h0200);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset_mid_drain");
    clear_model();
    out_ready = 1'b1;
    release_reset();

    // Back-to-back rows with in_valid held high.
    send(16'h0400); send(16'h0600); send(16'h0500); send(16'h0400);
    send(16'h0100); send(16'h0800); send(16'h0180); send(16'h0300);
    in_valid = 1'b0;
    wait_idle();

    // Randomized rows with random gaps and random backpressure.
    fork
      begin
        for (int r = 0; r < 30; r++) begin
          int kind;
          logic [IW-1:0] base;
          kind = $urandom_range(0, 2);
          base = IW'($urandom_range(0, 16'hF000));
          for (int e = 0; e < DL; e++) begin
            logic [IW-1:0] v;
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            case (kind)
              0:       v = IW'($urandom);
              1:       v = base + IW'($urandom_range(0, 16'h0FFF));
              default: v = base;
            endcase
            send(v);
          end
        end
        in_valid = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
